// File: rtl/multi_chan_trade_arbiter_pkg.sv
// Shared types, constants and helpers for the multi-channel trade arbiter and its round-robin stage.
package multi_chan_trade_arbiter_pkg;

  localparam int unsigned PRICE_W_DEF = 32;
  localparam int unsigned MAX_PRICE_W = 64;

  // Output FSM encoding
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;

  function automatic int unsigned chan_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Locked or crossed books yield zero so they can never qualify.
  function automatic logic [MAX_PRICE_W-1:0] calc_spread(input logic [MAX_PRICE_W-1:0] bid,
                                                         input logic [MAX_PRICE_W-1:0] ask);
    return (ask > bid) ? (ask - bid) : '0;
  endfunction

endpackage

// File: rtl/multi_chan_trade_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr_i, wrapping modulo N.
module multi_chan_trade_arbiter_rr_arbiter
  import multi_chan_trade_arbiter_pkg::*;
#(
  parameter int unsigned N    = 4,
  localparam int unsigned IdxW = chan_w(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] gnt_idx_o,
  output logic            any_o
);

  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr_i) + k) % N;
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = IdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/multi_chan_trade_arbiter.sv
// Tick-to-trade decision core: qualifies per-channel BBO spreads, arbitrates triggers round-robin
// onto one valid/ready order stream, with per-channel cooldown and a global token-bucket limiter.
module multi_chan_trade_arbiter
  import multi_chan_trade_arbiter_pkg::*;
#(
  parameter int unsigned N_CHAN        = 4,
  parameter int unsigned PRICE_W       = PRICE_W_DEF,
  parameter int unsigned DEF_THRESH    = 5,
  parameter int unsigned COOLDOWN      = 16,
  parameter int unsigned MAX_BURST     = 4,
  parameter int unsigned REFILL_CYCLES = 64,
  parameter int unsigned CNT_W         = 16,
  localparam int unsigned CHAN_W       = chan_w(N_CHAN)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_CHAN-1:0]           bbo_valid_i,
  input  logic [N_CHAN*PRICE_W-1:0]   bid_price_i,
  input  logic [N_CHAN*PRICE_W-1:0]   ask_price_i,
  input  logic [N_CHAN-1:0]           ai_pred_i,
  input  logic                        cfg_we_i,
  input  logic [PRICE_W-1:0]          spread_thresh_i,
  input  logic                        enable_i,
  output logic                        order_valid_o,
  input  logic                        order_ready_i,
  output logic [CHAN_W-1:0]           order_chan_o,
  output logic [PRICE_W-1:0]          order_spread_o,
  output logic [CNT_W-1:0]            drop_count_o
);

  localparam int unsigned CoolW = $clog2(COOLDOWN + 1);
  localparam int unsigned TokW  = $clog2(MAX_BURST + 1);
  localparam int unsigned RefW  = chan_w(REFILL_CYCLES);
  localparam int unsigned SumW  = CNT_W + CHAN_W + 1;

  logic [N_CHAN-1:0]              s1_valid_q, s1_pred_q;
  logic [N_CHAN-1:0][PRICE_W-1:0] s1_spread_q;
  logic [PRICE_W-1:0]             thresh_q;

  logic [N_CHAN-1:0]              pend_q, pend_d;
  logic [N_CHAN-1:0][PRICE_W-1:0] snap_q, snap_d;
  logic [N_CHAN-1:0][CoolW-1:0]   cool_q, cool_d;
  logic [TokW-1:0]                tok_q, tok_d;
  logic [RefW-1:0]                ref_q, ref_d;
  logic [0:0]                     state_q, state_d;
  logic [CHAN_W-1:0]              chan_q, chan_d, ptr_q, ptr_d;
  logic [PRICE_W-1:0]             spread_q, spread_d;
  logic [CNT_W-1:0]               drop_q, drop_d;

  logic [N_CHAN-1:0] accept, drop;
  logic [SumW-1:0]   n_drop, drop_sum;
  logic [N_CHAN-1:0] arb_gnt;
  logic [CHAN_W-1:0] arb_idx;
  logic              arb_any, grant, hs, refill;

  // Stage 1: spread and prediction capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q  <= '0;
      s1_pred_q   <= '0;
      s1_spread_q <= '0;
      thresh_q    <= PRICE_W'(DEF_THRESH);
    end else begin
      s1_valid_q <= bbo_valid_i;
      for (int unsigned i = 0; i < N_CHAN; i++) begin
        if (bbo_valid_i[i]) begin
          s1_spread_q[i] <= PRICE_W'(calc_spread(MAX_PRICE_W'(bid_price_i[i*PRICE_W +: PRICE_W]),
                                                 MAX_PRICE_W'(ask_price_i[i*PRICE_W +: PRICE_W])));
          s1_pred_q[i]   <= ai_pred_i[i];
        end
      end
      if (cfg_we_i) thresh_q <= spread_thresh_i;
    end
  end

  // Stage 2: qualification against the threshold, split by cooldown state
  always_comb begin
    accept = '0;
    drop   = '0;
    n_drop = '0;
    for (int unsigned i = 0; i < N_CHAN; i++) begin
      if (s1_valid_q[i] && s1_pred_q[i] && enable_i && (s1_spread_q[i] > thresh_q)) begin
        if (cool_q[i] == '0) accept[i] = 1'b1;
        else                 drop[i]   = 1'b1;
      end
      if (drop[i]) n_drop = n_drop + 1'b1;
    end
    drop_sum = SumW'(drop_q) + n_drop;
    drop_d   = (drop_sum > SumW'({CNT_W{1'b1}})) ? '1 : drop_sum[CNT_W-1:0];
  end

  multi_chan_trade_arbiter_rr_arbiter #(
    .N (N_CHAN)
  ) u_rr_arbiter (
    .req_i     (pend_q),
    .ptr_i     (ptr_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .any_o     (arb_any)
  );

  assign hs     = (state_q == ST_PRESENT) && order_ready_i;
  assign grant  = (state_q == ST_IDLE) && arb_any && (tok_q != '0);
  assign refill = (ref_q == RefW'(REFILL_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    spread_d = spread_q;
    ptr_d    = ptr_q;
    pend_d   = pend_q;
    snap_d   = snap_q;
    tok_d    = tok_q;
    ref_d    = refill ? '0 : ref_q + 1'b1;

    if (grant) begin
      state_d  = ST_PRESENT;
      chan_d   = arb_idx;
      spread_d = snap_q[arb_idx];
      pend_d   = pend_d & ~arb_gnt;
    end
    if (hs) begin
      state_d = ST_IDLE;
      ptr_d   = (chan_q == CHAN_W'(N_CHAN - 1)) ? '0 : chan_q + 1'b1;
    end

    for (int unsigned i = 0; i < N_CHAN; i++) begin
      cool_d[i] = (cool_q[i] != '0) ? cool_q[i] - 1'b1 : '0;
      if (hs && (chan_q == CHAN_W'(i))) cool_d[i] = CoolW'(COOLDOWN);
      // A fresh trigger overrides a grant-clear on the same channel; latest snapshot wins.
      if (accept[i]) begin
        pend_d[i] = 1'b1;
        snap_d[i] = s1_spread_q[i];
      end
    end
    if (!enable_i) pend_d = '0;

    if (hs && !refill)                                       tok_d = tok_q - 1'b1;
    else if (refill && !hs && (tok_q != TokW'(MAX_BURST)))  tok_d = tok_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      chan_q   <= '0;
      spread_q <= '0;
      ptr_q    <= '0;
      pend_q   <= '0;
      snap_q   <= '0;
      cool_q   <= '0;
      tok_q    <= TokW'(MAX_BURST);
      ref_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      chan_q   <= chan_d;
      spread_q <= spread_d;
      ptr_q    <= ptr_d;
      pend_q   <= pend_d;
      snap_q   <= snap_d;
      cool_q   <= cool_d;
      tok_q    <= tok_d;
      ref_q    <= ref_d;
      drop_q   <= drop_d;
    end
  end

  assign order_valid_o  = (state_q == ST_PRESENT);
  assign order_chan_o   = chan_q;
  assign order_spread_o = spread_q;
  assign drop_count_o   = drop_q;

endmodule
